// File: rtl/scr1_memif_pkg.sv
// Shared memory-interface types plus TCM dmem port lane and response context types.
// Optional build macro used by the dmem port: SCR1_TCM_DMEM_RDBUF_EN.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD,
    SCR1_MEM_CMD_WR
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE,
    SCR1_MEM_WIDTH_HWORD,
    SCR1_MEM_WIDTH_WORD,
    SCR1_MEM_WIDTH_ERROR
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY,
    SCR1_MEM_RESP_RDY_OK,
    SCR1_MEM_RESP_RDY_ER
  } type_scr1_mem_resp_e;

  localparam logic [3:0] SCR1_TCM_BE_BYTE  = 4'b0001;
  localparam logic [3:0] SCR1_TCM_BE_HWORD = 4'b0011;
  localparam logic [3:0] SCR1_TCM_BE_WORD  = 4'b1111;

  typedef enum logic {
    RESP_IDLE,
    RESP_PEND
  } type_scr1_tcm_resp_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic                 is_read;
    logic [1:0]           offset;
    type_scr1_mem_width_e width;
  } type_scr1_tcm_resp_ctx_s;

endpackage

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane helpers for TCM ports: write replicate/byte-enable
// and read shift/zero-extend.
module scr1_tcm_lane_align
  import scr1_memif_pkg::*;
#(
  parameter int W  = 32,
  parameter int NB = W/8
) (
  input  type_scr1_mem_width_e wr_width,
  input  logic [1:0]           wr_offset,
  input  logic [W-1:0]         wr_data,
  output logic [NB-1:0]        wr_be,
  output logic [W-1:0]         wr_lanes,
  input  type_scr1_mem_width_e rd_width,
  input  logic [1:0]           rd_offset,
  input  logic [W-1:0]         rd_word,
  output logic [W-1:0]         rd_data
);

  logic [W-1:0] shifted;

  always_comb begin
    wr_be    = '0;
    wr_lanes = wr_data;
    unique case (1'b1)
      (wr_width == SCR1_MEM_WIDTH_BYTE): begin
        wr_be    = SCR1_TCM_BE_BYTE << wr_offset;
        wr_lanes = {4{wr_data[7:0]}};
      end
      (wr_width == SCR1_MEM_WIDTH_HWORD): begin
        wr_be    = SCR1_TCM_BE_HWORD << wr_offset;
        wr_lanes = {2{wr_data[15:0]}};
      end
      (wr_width == SCR1_MEM_WIDTH_WORD): begin
        wr_be    = SCR1_TCM_BE_WORD;
        wr_lanes = wr_data;
      end
      default: begin
        wr_be    = '0;
        wr_lanes = wr_data;
      end
    endcase
  end

  assign shifted = rd_word >> {rd_offset, 3'b000};

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (rd_width == SCR1_MEM_WIDTH_BYTE):
        rd_data = {24'd0, shifted[7:0]};
      (rd_width == SCR1_MEM_WIDTH_HWORD):
        rd_data = {16'd0, shifted[15:0]};
      (rd_width == SCR1_MEM_WIDTH_WORD):
        rd_data = rd_word;
      default:
        rd_data = '0;
    endcase
  end

endmodule

// File: rtl/scr1_tcm_dmem_port.sv
// Core dmem to TCM port B adapter with alignment/range checking.
// SCR1_TCM_DMEM_RDBUF_EN adds a registered response stage (latency 2).
module scr1_tcm_dmem_port
  import scr1_memif_pkg::*;
#(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 32'h00010000,
  parameter int SCR1_NBYTES = SCR1_WIDTH/8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dmem_req,
  output logic                          dmem_req_ack,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [31:0]                   dmem_addr,
  input  logic [SCR1_WIDTH-1:0]         dmem_wdata,
  output logic [SCR1_WIDTH-1:0]         dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic                          renb,
  output logic                          wenb,
  output logic [SCR1_NBYTES-1:0]        webb,
  output logic [$clog2(SCR1_SIZE)-3:0]  addrb,
  output logic [SCR1_WIDTH-1:0]         datab,
  input  logic [SCR1_WIDTH-1:0]         qb
);

  localparam int AW = $clog2(SCR1_SIZE);

  logic                      aligned;
  logic                      in_range;
  logic                      ok;
  logic [SCR1_NBYTES-1:0]    be;
  logic [SCR1_WIDTH-1:0]     rd_data;
  type_scr1_tcm_resp_state_e state;
  type_scr1_tcm_resp_ctx_s   ctx;
  type_scr1_mem_resp_e       resp_c;
  logic [SCR1_WIDTH-1:0]     rdata_c;

  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      (dmem_width == SCR1_MEM_WIDTH_BYTE):  aligned = 1'b1;
      (dmem_width == SCR1_MEM_WIDTH_HWORD): aligned = ~dmem_addr[0];
      (dmem_width == SCR1_MEM_WIDTH_WORD):  aligned = (dmem_addr[1:0] == 2'b00);
      default:                              aligned = 1'b0;
    endcase
  end

  assign in_range     = (dmem_addr[31:AW] == '0);
  assign ok           = aligned & in_range;
  assign dmem_req_ack = dmem_req & rst_n;

  assign renb  = dmem_req_ack & ok & (dmem_cmd == SCR1_MEM_CMD_RD);
  assign wenb  = dmem_req_ack & ok & (dmem_cmd == SCR1_MEM_CMD_WR);
  assign webb  = wenb ? be : '0;
  assign addrb = dmem_addr[AW-1:2];

  scr1_tcm_lane_align #(
    .W  (SCR1_WIDTH),
    .NB (SCR1_NBYTES)
  ) i_align (
    .wr_width  (dmem_width),
    .wr_offset (dmem_addr[1:0]),
    .wr_data   (dmem_wdata),
    .wr_be     (be),
    .wr_lanes  (datab),
    .rd_width  (ctx.width),
    .rd_offset (ctx.offset),
    .rd_word   (qb),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESP_IDLE;
      ctx   <= '0;
    end else if (dmem_req_ack) begin
      state <= RESP_PEND;
      ctx   <= '{
        valid:   1'b1,
        err:     ~ok,
        is_read: (dmem_cmd == SCR1_MEM_CMD_RD),
        offset:  dmem_addr[1:0],
        width:   dmem_width
      };
    end else begin
      state <= RESP_IDLE;
      ctx   <= '0;
    end
  end

  always_comb begin
    resp_c  = SCR1_MEM_RESP_NOTRDY;
    rdata_c = '0;
    if (state == RESP_PEND) begin
      resp_c = ctx.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      if (ctx.valid & ~ctx.err & ctx.is_read)
        rdata_c = rd_data;
    end
  end

`ifdef SCR1_TCM_DMEM_RDBUF_EN
  type_scr1_mem_resp_e   resp_q;
  logic [SCR1_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= SCR1_MEM_RESP_NOTRDY;
      rdata_q <= '0;
    end else begin
      resp_q  <= resp_c;
      rdata_q <= rdata_c;
    end
  end

  assign dmem_resp  = resp_q;
  assign dmem_rdata = rdata_q;
`else
  assign dmem_resp  = resp_c;
  assign dmem_rdata = rdata_c;
`endif

endmodule

// File: doc/scr1_tcm_dmem_port.md
Name: scr1_tcm_dmem_port

Overview:
- Data-side adapter between the core dmem request/response interface and port B of the TCM dual-port memory (renb/wenb/webb/addrb/datab/qb).
- Accepts one dmem request per cycle and drives memory port B in the same cycle.
- Returns write acknowledgements and byte-aligned read data one cycle later.
- Flags misaligned and out-of-range accesses with an error response; those accesses never touch memory.

Parameters:
SCR1_WIDTH, 32, data word width in bits (only 32 supported)
SCR1_SIZE, 32'h00010000, TCM size in bytes (power of two)
SCR1_NBYTES, SCR1_WIDTH/8, byte lanes per word

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dmem_req  in  1  request valid
dmem_req_ack  out  1  request accepted (combinational)
dmem_cmd  in  type_scr1_mem_cmd_e  READ / WRITE
dmem_width  in  type_scr1_mem_width_e  BYTE / HWORD / WORD
dmem_addr  in  32  byte address (TCM-relative low bits used)
dmem_wdata  in  32  write data, LSB-justified
dmem_rdata  out  32  read data, LSB-justified, zero-extended
dmem_resp  out  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
renb  out  1  port B read enable
wenb  out  1  port B write enable
webb  out  SCR1_NBYTES  port B byte write enables
addrb  out  $clog2(SCR1_SIZE)-2  port B word address = dmem_addr[$clog2(SCR1_SIZE)-1:2]
datab  out  32  port B write data, lane-shifted
qb  in  32  port B read data, valid the cycle after renb

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Acknowledge: dmem_req_ack = dmem_req & rst_n. There are no stall cycles, and back-to-back requests are accepted every cycle.
- Legality check, done in the request cycle:
  - ok = aligned & in_range.
  - Aligned means: HWORD requires addr[0]=0; WORD requires addr[1:0]=0; BYTE is always aligned.
  - in_range requires dmem_addr[31:$clog2(SCR1_SIZE)] == 0.
- Memory drive, combinational, in the acknowledge cycle:
  - renb = req & ok & cmd==READ.
  - wenb = req & ok & cmd==WRITE.
  - webb: BYTE = 4'b0001<<addr[1:0]; HWORD = 4'b0011<<addr[1:0]; WORD = 4'b1111. webb = 0 whenever wenb = 0.
  - datab: dmem_wdata replicated per width (byte x4, halfword x2, word x1), so every enabled lane carries the correct data.
- Response register: state is RESP_IDLE or RESP_PEND; the register captures {valid, err, is_read, offset[1:0], width}.
  - Request accepted -> next cycle RESP_PEND. dmem_resp = RDY_ER if err, else RDY_OK.
  - No request -> RESP_IDLE. dmem_resp = NOTRDY.
  - PEND followed by a new accept stays in PEND; responses come back-to-back, strictly in order, latency exactly 1.
- Read data, combinational from qb in the response cycle:
  - shifted = qb >> (8*offset).
  - BYTE returns zero-extended [7:0]; HWORD returns zero-extended [15:0]; WORD returns qb.
  - dmem_rdata = 0 for writes, errors, and NOTRDY.
- Same-address write then read in consecutive cycles: ordering is guaranteed by single-port sequencing, so no forwarding is needed.
- Reset values: dmem_resp = NOTRDY, dmem_rdata = 0, state RESP_IDLE. renb/wenb/webb are 0 while rst_n = 0.
- Reset asserted while a response is pending: the response is dropped, no resp is issued, and a write already committed to memory stays committed.

Optional Feature:
- SCR1_TCM_DMEM_RDBUF_EN
- Defined:
  - Adds a 1-entry registered output buffer. dmem_rdata/dmem_resp come from flops, giving total latency 2; the ack rule is unchanged.
  - Memory qb is captured in RESP_PEND and presented in the next cycle.
  - Two-stage valid pipeline; ordering is preserved.
  - Improves timing toward the LSU.
- Undefined: latency 1, as above.

Decomposition:
- type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e come from the shared scr1_memif_pkg.
- Add to that package:
  - localparam SCR1_TCM_BE_BYTE = 4'b0001
  - localparam SCR1_TCM_BE_HWORD = 4'b0011
  - localparam SCR1_TCM_BE_WORD = 4'b1111
  - typedef struct type_scr1_tcm_resp_ctx_s {valid, err, is_read, offset, width}
- One natural sub-module: scr1_tcm_lane_align. It is combinational and provides the write replicate/byte-enable function and the read shift/extend function, reused later by the imem side.

Test Plan:
- WORD write addr 0x10 data 0xDEADBEEF, then WORD read 0x10:
  - write cycle: wenb=1, webb=4'hF, addrb=4;
  - next cycle: RDY_OK;
  - read response: rdata=0xDEADBEEF.
- BYTE write 0xA5 at 0x13, then WORD read 0x10 -> webb=4'b1000, datab=0xA5A5A5A5; read returns 0xA5ADBEEF.
- HWORD read at 0x12 over a word holding 0x12345678 -> rdata=0x00001234.
- HWORD read at 0x11 -> renb=0, next cycle RDY_ER, rdata=0. WORD write at 0x00010000 -> wenb=0, RDY_ER.
- Four consecutive reads 0x0, 0x4, 0x8, 0xC with ack=1 every cycle -> four consecutive RDY_OK responses in order, each with latency 1 (latency 2 with SCR1_TCM_DMEM_RDBUF_EN).
- Read accepted, then rst_n deasserted to 0 in the response cycle -> dmem_resp=NOTRDY immediately and no response after reset release. A write accepted just before reset remains visible to a later read.
